// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, arbiter states and opcode legality.
package alu_pkg;

  localparam int ALU_WIDTH = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NEG = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NEG: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Command (two requesters) and response bundle of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_id;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_id, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/xor/negate with {N,Z,C,V} flags; zero latency, no flow control.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;

  // Sub and negate share the adder as x + ~y + 1, so C means "no borrow".
  always_comb begin
    x      = a;
    y      = b;
    cin    = 1'b0;
    arith  = 1'b0;
    result = '0;
    case (op)
      ALU_ADD: arith = 1'b1;
      ALU_SUB: begin y = ~b; cin = 1'b1; arith = 1'b1; end
      ALU_NEG: begin x = '0; y = ~a; cin = 1'b1; arith = 1'b1; end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    if (arith) result = sum[WIDTH-1:0];
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = arith & sum[WIDTH];
    flags[FLAG_V] = arith & (x[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one alu between two requesters; response valid two edges after accept.
// One operation in flight; rsp_ready low holds the response and blocks new commands.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  if (WIDTH != ALU_WIDTH) begin : g_bad_width
    $error("alu_arbiter: WIDTH must equal the alu width");
  end

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             last_grant;
  logic             any_vld;
  logic             gnt_id;
  logic             accept;

  logic [WIDTH-1:0] hold_a;
  logic [WIDTH-1:0] hold_b;
  logic [2:0]       hold_op;
  logic             hold_id;

  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_id_q;
  logic             rsp_err_q;

  assign any_vld = bus.req0_valid | bus.req1_valid;
  // Contention goes to whoever was not served last; otherwise to the lone requester.
  assign gnt_id  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld && !reset) begin
          accept         = 1'b1;
          bus.req0_ready = ~gnt_id;
          bus.req1_ready = gnt_id;
          state_nxt      = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= 1'b1;
      hold_a       <= '0;
      hold_b       <= '0;
      hold_op      <= '0;
      hold_id      <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        hold_a     <= gnt_id ? bus.req1_a  : bus.req0_a;
        hold_b     <= gnt_id ? bus.req1_b  : bus.req0_b;
        hold_op    <= gnt_id ? bus.req1_op : bus.req0_op;
        hold_id    <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_id_q <= hold_id;
        if (is_legal_op(hold_op)) begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags;
          rsp_err_q    <= 1'b0;
        end else begin
          rsp_result_q <= '0;
          rsp_flags_q  <= '0;
          rsp_err_q    <= 1'b1;
        end
      end
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (hold_a),
    .b      (hold_b),
    .op     (hold_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
